keypad_scanner: RTL and testbench

- Scans a 4x4 matrix keypad by driving one row at a time, one-hot, and sampling the 4 column lines.
- Detects a pressed key, latches its 4-bit hex code and holds it while the key stays down.
- Feeds the downstream key-register / display logic of the keypad lab. Synchronous to a single system clock.

---
 rtl/keypad_scanner_if.sv | 11 +
 rtl/keypad_scanner.sv | 169 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 120 ++++++++++++
 3 files changed

// File: rtl/keypad_scanner_if.sv
// Keypad scanner bundle: column sense in, row drive and decoded key out.
// master = scanner side, slave = keypad matrix / key-register side.
interface keypad_scanner_if;
    logic [3:0] columns;      // column lines, bit3 = column 1 (leftmost)
    logic [3:0] row;          // one-hot row drive, 4'b1000 = row 1
    logic       key_pressed;  // high while a key is held
    logic [3:0] value;        // hex code of the last accepted key

    modport master (input columns, output row, key_pressed, value);
    modport slave  (output columns, input row, key_pressed, value);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: sweeps rows one-hot, latches the hex code of
// the first key seen and holds it while the key stays down.
// Optional press/release debounce enabled by defining KEYPAD_DEBOUNCE_EN;
// DEBOUNCE_CYCLES sets the number of stable cycles required.
module keypad_scanner #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,   // asynchronous, active-low
    keypad_scanner_if.master  kp
);

    // Low two bits carry the row index, bit 2 marks a pressed state.
    // Encodings 8..15 are never entered and fall back to ROW1.
    typedef enum logic [3:0] {
        ROW1 = 4'd0, ROW2 = 4'd1, ROW3 = 4'd2, ROW4 = 4'd3,
        R1P  = 4'd4, R2P  = 4'd5, R3P  = 4'd6, R4P  = 4'd7
    } state_t;

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("keypad_scanner: DEBOUNCE_CYCLES must be at least 1");
    end

    state_t     state_q, state_d;
    logic [3:0] value_q, value_d;
    logic [3:0] row_q, row_d;
    logic       key_pressed_q, key_pressed_d;

`ifdef KEYPAD_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [3:0]       pat_q, pat_d;   // column pattern being qualified
`endif

    // Column index of the highest set bit (0 = column 1).
    function automatic logic [1:0] col_sel(input logic [3:0] cols);
        if (cols[3])      col_sel = 2'd0;
        else if (cols[2]) col_sel = 2'd1;
        else if (cols[1]) col_sel = 2'd2;
        else              col_sel = 2'd3;
    endfunction

    // Keypad legend lookup by row index and column index.
    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'b00_00: key_code = 4'hA;
            4'b00_01: key_code = 4'h0;
            4'b00_10: key_code = 4'hB;
            4'b00_11: key_code = 4'hF;
            4'b01_00: key_code = 4'h4;
            4'b01_01: key_code = 4'h5;
            4'b01_10: key_code = 4'h6;
            4'b01_11: key_code = 4'hE;
            4'b10_00: key_code = 4'h7;
            4'b10_01: key_code = 4'h8;
            4'b10_10: key_code = 4'h9;
            4'b10_11: key_code = 4'hC;
            4'b11_00: key_code = 4'h1;
            4'b11_01: key_code = 4'h2;
            4'b11_10: key_code = 4'h3;
            default:  key_code = 4'hD;
        endcase
    endfunction

    // Row n lights bit (4-n); both ROWn and RnP drive the same row.
    function automatic logic [3:0] row_drive(input state_t s);
        row_drive = 4'b1000 >> s[1:0];
    endfunction

    // Next-state and latch logic; row/key_pressed are decoded from the
    // next state so the registered outputs line up with the state flop.
    always_comb begin
        state_d = state_q;
        value_d = value_q;
`ifdef KEYPAD_DEBOUNCE_EN
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        cnt_inc = (cnt_q == CNT_DONE) ? cnt_q : cnt_q + 1'b1;
`endif
        case (state_q)
            ROW1, ROW2, ROW3, ROW4: begin
                if (kp.columns == 4'b0000) begin
                    state_d = state_t'({2'b00, state_q[1:0] + 2'd1});
`ifdef KEYPAD_DEBOUNCE_EN
                    cnt_d   = '0;
                    pat_d   = 4'b0000;
`endif
                end else begin
`ifdef KEYPAD_DEBOUNCE_EN
                    // Count consecutive cycles of an identical pattern,
                    // holding the row until it has been stable long enough.
                    if (kp.columns != pat_q || cnt_q == '0)
                        cnt_inc = CNT_W'(1);
                    if (cnt_inc >= CNT_DONE) begin
                        state_d = state_t'({2'b01, state_q[1:0]});
                        value_d = key_code(state_q[1:0], col_sel(kp.columns));
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_inc;
                    end
                    pat_d = kp.columns;
`else
                    state_d = state_t'({2'b01, state_q[1:0]});
                    value_d = key_code(state_q[1:0], col_sel(kp.columns));
`endif
                end
            end
            R1P, R2P, R3P, R4P: begin
`ifdef KEYPAD_DEBOUNCE_EN
                // Release only after a long enough run of idle columns.
                if (kp.columns == 4'b0000) begin
                    if (cnt_inc >= CNT_DONE) begin
                        state_d = state_t'({2'b00, state_q[1:0]});
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_inc;
                    end
                end else begin
                    cnt_d = '0;
                end
                pat_d = 4'b0000;
`else
                if (kp.columns == 4'b0000)
                    state_d = state_t'({2'b00, state_q[1:0]});
`endif
            end
            default: begin
                state_d = ROW1;
`ifdef KEYPAD_DEBOUNCE_EN
                cnt_d   = '0;
                pat_d   = 4'b0000;
`endif
            end
        endcase
        row_d         = row_drive(state_d);
        key_pressed_d = state_d[2];
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ROW1;
            value_q       <= 4'h0;
            row_q         <= 4'b1000;
            key_pressed_q <= 1'b0;
`ifdef KEYPAD_DEBOUNCE_EN
            cnt_q         <= '0;
            pat_q         <= 4'b0000;
`endif
        end else begin
            state_q       <= state_d;
            value_q       <= value_d;
            row_q         <= row_d;
            key_pressed_q <= key_pressed_d;
`ifdef KEYPAD_DEBOUNCE_EN
            cnt_q         <= cnt_d;
            pat_q         <= pat_d;
`endif
        end
    end

    assign kp.row         = row_q;
    assign kp.key_pressed = key_pressed_q;
    assign kp.value       = value_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (default build, no debounce).
module tb_keypad_scanner;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    keypad_scanner_if kif ();

    keypad_scanner #(.DEBOUNCE_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .kp    (kif)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic expect_out(input string tag, input logic [3:0] e_row,
                              input logic e_kp, input logic [3:0] e_val);
        chk1({tag, ".row"},   kif.row,                 e_row);
        chk1({tag, ".kp"},    {3'b000, kif.key_pressed}, {3'b000, e_kp});
        chk1({tag, ".value"}, kif.value,               e_val);
    endtask

    initial begin
        kif.columns = 4'b0000;
        reset = 1'b0;
        repeat (2) tick();
        expect_out("reset", 4'b1000, 1'b0, 4'h0);
        #2 reset = 1'b1;

        // free-running sweep
        tick(); expect_out("scan2", 4'b0100, 1'b0, 4'h0);
        tick(); expect_out("scan3", 4'b0010, 1'b0, 4'h0);
        tick(); expect_out("scan4", 4'b0001, 1'b0, 4'h0);
        tick(); expect_out("wrap1", 4'b1000, 1'b0, 4'h0);

        // row1/col1 -> A, held then released back to ROW1
        kif.columns = 4'b1000;
        tick(); expect_out("pressA", 4'b1000, 1'b1, 4'hA);
        repeat (3) begin tick(); expect_out("holdA", 4'b1000, 1'b1, 4'hA); end
        kif.columns = 4'b0000;
        tick(); expect_out("relA",  4'b1000, 1'b0, 4'hA);
        tick(); expect_out("postA", 4'b0100, 1'b0, 4'hA);

        // row2/col2 -> 5
        kif.columns = 4'b0100;
        tick(); expect_out("press5", 4'b0100, 1'b1, 4'h5);
        kif.columns = 4'b0000;
        tick(); expect_out("rel5",  4'b0100, 1'b0, 4'h5);
        tick(); expect_out("post5", 4'b0010, 1'b0, 4'h5);

        // row3/col3 -> 9
        kif.columns = 4'b0010;
        tick(); expect_out("press9", 4'b0010, 1'b1, 4'h9);
        kif.columns = 4'b0000;
        tick(); expect_out("rel9",  4'b0010, 1'b0, 4'h9);
        tick(); expect_out("post9", 4'b0001, 1'b0, 4'h9);

        // row4/col4 -> D
        kif.columns = 4'b0001;
        tick(); expect_out("pressD", 4'b0001, 1'b1, 4'hD);
        kif.columns = 4'b0000;
        tick(); expect_out("relD",  4'b0001, 1'b0, 4'hD);
        tick(); expect_out("postD", 4'b1000, 1'b0, 4'hD);
        tick(); expect_out("idle2", 4'b0100, 1'b0, 4'hD);

        // priority in row2: 1100 -> col1 -> 4; later column changes ignored
        kif.columns = 4'b1100;
        tick(); expect_out("prio4", 4'b0100, 1'b1, 4'h4);
        kif.columns = 4'b0010;
        tick(); expect_out("ignore", 4'b0100, 1'b1, 4'h4);
        kif.columns = 4'b0000;
        tick(); expect_out("rel4",  4'b0100, 1'b0, 4'h4);
        tick(); expect_out("post4a", 4'b0010, 1'b0, 4'h4);
        tick(); expect_out("post4b", 4'b0001, 1'b0, 4'h4);

        // all columns in row4 -> col1 -> 1
        kif.columns = 4'b1111;
        tick(); expect_out("prio1", 4'b0001, 1'b1, 4'h1);
        kif.columns = 4'b0000;
        tick(); expect_out("rel1",  4'b0001, 1'b0, 4'h1);
        tick(); expect_out("post1a", 4'b1000, 1'b0, 4'h1);
        tick(); expect_out("post1b", 4'b0100, 1'b0, 4'h1);
        tick(); expect_out("post1c", 4'b0010, 1'b0, 4'h1);

        // press 9 again, then reset asynchronously mid-press
        kif.columns = 4'b0010;
        tick(); expect_out("press9b", 4'b0010, 1'b1, 4'h9);
        #2 reset = 1'b0;
        #1 expect_out("async_rst", 4'b1000, 1'b0, 4'h0);
        tick(); expect_out("rst_hold", 4'b1000, 1'b0, 4'h0);

        // row3 key still held: sensed only once row3 is driven again
        kif.columns = 4'b0000;
        #2 reset = 1'b1;
        tick(); expect_out("rs_scan2", 4'b0100, 1'b0, 4'h0);
        tick(); expect_out("rs_scan3", 4'b0010, 1'b0, 4'h0);
        kif.columns = 4'b0010;
        tick(); expect_out("rs_press9", 4'b0010, 1'b1, 4'h9);
        kif.columns = 4'b0000;
        tick(); expect_out("rs_rel9", 4'b0010, 1'b0, 4'h9);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
